count_piso_tx: RTL and testbench

- Downstream consumer of the 4-bit loadable up counter and the MOD12 counter.
- Accepts one parallel count word per valid/ready handshake and transmits it on a single serial line as a framed bit stream: start bit, data bits, optional even parity, stop bit.
- Turns the counters' parallel output into the serial form that the SISO and shift-register stages consume.
- Sequential throughout: a frame FSM, a shift register and a bit counter.

---
 rtl/count_piso_tx.sv | 133 +++++++++++++
 tb/tb_count_piso_tx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/count_piso_tx.sv
// count_piso_tx: parallel-in / serial-out frame transmitter.
// Accepts one WIDTH-bit word per valid/ready handshake and sends it on a
// single registered line as: start bit (0), data bits, optional even parity,
// stop bit (1). The line idles high.
//
// Parameters:
//   WIDTH     - data word width (1..16)
//   MSB_FIRST - 1: in_data[WIDTH-1] goes out first, 0: in_data[0] first
//   PARITY_EN - 1: append even parity over the data bits
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset
//   in_valid - in_data holds a word to send
//   in_ready - block can take a word this cycle (state decode only)
//   in_data  - parallel word, captured on the accepting edge
//   ser_out  - registered serial line
//   busy     - high from the start bit through the stop bit
//   done     - one-cycle pulse coincident with the stop bit
module count_piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt, shifted;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             par, par_nxt;
    logic             ser_nxt, busy_nxt, done_nxt;
    logic             accept, cur_bit;

    assign in_ready = (state == IDLE) || (state == STOP);
    assign accept   = in_valid && in_ready;

    // The bit about to be presented always sits at the outgoing end.
    assign cur_bit  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign shifted  = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

    // Outputs are registered, so everything here is computed for the
    // state being entered, not the current one.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        par_nxt   = par;
        ser_nxt   = 1'b1;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = START;
                    shreg_nxt = in_data;
                    par_nxt   = ^in_data;
                end
            end
            START: begin
                state_nxt = DATA;
                cnt_nxt   = '0;
                ser_nxt   = cur_bit;
                shreg_nxt = shifted;
            end
            DATA: begin
                if (cnt == LAST) begin
                    if (PARITY_EN) begin
                        state_nxt = PARITY;
                        ser_nxt   = par;
                    end else begin
                        state_nxt = STOP;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    ser_nxt   = cur_bit;
                    shreg_nxt = shifted;
                end
            end
            PARITY: begin
                state_nxt = STOP;
                done_nxt  = 1'b1;
            end
            STOP: begin
                // Back-to-back: a word taken during the stop bit starts
                // its frame on the very next cycle.
                if (accept) begin
                    state_nxt = START;
                    shreg_nxt = in_data;
                    par_nxt   = ^in_data;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == START) ser_nxt = 1'b0;
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            par     <= 1'b0;
            ser_out <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            cnt     <= cnt_nxt;
            par     <= par_nxt;
            ser_out <= ser_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_count_piso_tx.sv
// Bench for count_piso_tx: two instances (MSB-first with parity, LSB-first
// without parity). A reference model keeps, per instance, the list of line
// values still to be shown; its front is the expected ser_out, and busy,
// done and in_ready follow from the list length. Frames are built from the
// word with plain bit indexing. DUT0 frames are also decoded back to words.
module tb_count_piso_tx;

    typedef bit bq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       v0, v1;
    logic [3:0] d0, d1;
    logic       rdy0, ser0, busy0, done0;
    logic       rdy1, ser1, busy1, done1;

    always #5 clk = ~clk;

    count_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) u0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
        .ser_out(ser0), .busy(busy0), .done(done0)
    );

    count_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
        .ser_out(ser1), .busy(busy1), .done(done1)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bq_t frame(input logic [3:0] w, input bit msb, input bit par);
        bq_t f;
        f.push_back(1'b0);
        for (int b = 0; b < 4; b++) f.push_back(w[msb ? 3 - b : b]);
        if (par) f.push_back(^w);
        f.push_back(1'b1);
        return f;
    endfunction

    // ---------------- reference model ----------------
    bit         q0[$], q1[$];
    bit         acc0 = 1'b0, acc1 = 1'b0;
    logic [3:0] sent[$];
    bit         dec[$];

    always @(posedge clk) begin
        if (rst) begin
            q0.delete(); q1.delete(); sent.delete(); dec.delete();
            acc0 = 1'b0; acc1 = 1'b0;
        end else begin
            // Ready while idle or while the stop bit is on the line.
            acc0 = v0 && (q0.size() <= 1);
            acc1 = v1 && (q1.size() <= 1);
            if (q0.size() > 0) void'(q0.pop_front());
            if (q1.size() > 0) void'(q1.pop_front());
            if (acc0) begin
                q0 = {q0, frame(d0, 1'b1, 1'b1)};
                sent.push_back(d0);
            end
            if (acc1) q1 = {q1, frame(d1, 1'b0, 1'b0)};
        end
    end

    // ---------------- per-cycle checks ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ser0",  ser0,  (q0.size() > 0) ? q0[0] : 1'b1);
            chk("busy0", busy0, q0.size() != 0);
            chk("done0", done0, q0.size() == 1);
            chk("rdy0",  rdy0,  q0.size() <= 1);
            chk("ser1",  ser1,  (q1.size() > 0) ? q1[0] : 1'b1);
            chk("busy1", busy1, q1.size() != 0);
            chk("done1", done1, q1.size() == 1);
            chk("rdy1",  rdy1,  q1.size() <= 1);
            if (busy0 === 1'b1) dec.push_back(ser0);
            if (done0 === 1'b1) begin
                if (dec.size() == 7 && sent.size() > 0)
                    chk("decode0", {dec[1], dec[2], dec[3], dec[4]}, sent.pop_front());
                else
                    chk("decode0_frame", dec.size() * 100 + sent.size(), 701);
                dec.delete();
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input int i, input logic [3:0] w, input bit last);
        int  n = 0;
        bit  got;
        if (i == 0) begin v0 = 1'b1; d0 = w; end
        else        begin v1 = 1'b1; d1 = w; end
        do begin
            @(posedge clk); #1;
            n++;
            got = (i == 0) ? acc0 : acc1;
        end while (!got && n < 40);
        if (!got) chk("accept_timeout", 0, 1);
        if (last) begin
            if (i == 0) v0 = 1'b0;
            else        v1 = 1'b0;
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [3:0] cnt;
        int         g;
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 4'hA; d1 = 4'h5;
        // Reset held two cycles with valid asserted: no frame may start.
        @(posedge clk); #1 chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
        gap(2);

        // Single frame followed by a back-to-back held word.
        send(0, 4'b1011, 1'b0);
        send(0, 4'b0000, 1'b1);
        gap(9);
        send(0, 4'b1111, 1'b1);
        gap(9);

        // Reset during the second data bit, then a clean frame.
        send(0, 4'b1010, 1'b1);
        gap(3);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        send(0, 4'b0110, 1'b1);
        gap(9);

        // MOD12 counter feeding the transmitter, across the 11->0 wrap.
        cnt = 4'd8;
        repeat (14) begin
            g = $urandom_range(0, 2);
            send(0, cnt, g != 0);
            cnt = (cnt == 4'd11) ? 4'd0 : cnt + 4'd1;
            gap(g);
        end
        v0 = 1'b0;
        gap(9);

        // Random words with random gaps.
        repeat (20) begin
            g = $urandom_range(0, 3);
            send(0, 4'($urandom), g != 0);
            gap(g);
        end
        v0 = 1'b0;
        gap(9);

        // LSB-first, no parity instance.
        send(1, 4'b0001, 1'b1);
        gap(8);
        repeat (15) begin
            g = $urandom_range(0, 2);
            send(1, 4'($urandom), g != 0);
            gap(g);
        end
        v1 = 1'b0;
        gap(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
